// File: rtl/mult_queue_pkg.sv
// Shared types and defaults for the multiplier request queue.
// Holds the FSM state encoding, data width and the FIFO entry layout.
package mult_queue_pkg;

   localparam int DATA_W      = 32;
   localparam int DEPTH_DEF   = 4;
   localparam int TIMEOUT_DEF = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2
   } state_e;

   // One queued operand pair; packs as {a, b} (64 bits).
   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } req_t;

endpackage

// File: rtl/mult_queue_if.sv
// Bundle of the request, multiplier and result handshakes around mult_queue.
// The queue uses the slave view; the surrounding environment uses the master view.
interface mult_queue_if;
   import mult_queue_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic [DATA_W-1:0] req_a;
   logic [DATA_W-1:0] req_b;

   logic [DATA_W-1:0] mult_a;
   logic [DATA_W-1:0] mult_b;
   logic              doMult;
   logic              mult_done;
   logic [DATA_W-1:0] mult_out;

   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_out;
   logic              err_timeout;

   modport slave (
      input  req_valid, req_a, req_b, mult_done, mult_out, res_ready,
      output req_ready, mult_a, mult_b, doMult, res_valid, res_out, err_timeout
   );

   modport master (
      output req_valid, req_a, req_b, mult_done, mult_out, res_ready,
      input  req_ready, mult_a, mult_b, doMult, res_valid, res_out, err_timeout
   );

endinterface

// File: rtl/mult_req_fifo.sv
// Operand-pair FIFO with synchronous-read storage: a freshly written entry is
// presented at head_o (empty_o low) one cycle after it lands in the array.
module mult_req_fifo
   import mult_queue_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  req_t                       push_data_i,
   input  logic                       pop_i,
   output req_t                       head_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   req_t             mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   req_t             head_q;
   logic             head_vld_q;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = !head_vld_q;
   assign head_o  = head_q;
   assign count_o = count_q;

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && head_vld_q;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // NOTE: the storage array has no reset; count and pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         head_q     <= '0;
         head_vld_q <= 1'b0;
      end else begin
         count_q <= count_d;
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         // Head is refetched the cycle after a pop, once rd_ptr_q points at the next entry.
         head_q     <= mem_q[rd_ptr_q];
         head_vld_q <= (count_q != '0) && !pop_ok;
      end
   end

endmodule

// File: rtl/mult_queue.sv
// Queues operand pairs and feeds them one at a time to an external multu,
// holding each product in a single result slot with a per-operation timeout.
module mult_queue
   import mult_queue_pkg::*;
#(
   parameter int DEPTH   = DEPTH_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic         clk,
   input  logic         reset,
   mult_queue_if.slave  bus
);

   localparam int CNT_W  = $clog2(TIMEOUT+1);
   localparam int FCNT_W = $clog2(DEPTH+1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [DATA_W-1:0] mult_a_q, mult_b_q;
   logic [DATA_W-1:0] res_out_q;
   logic              res_valid_q;
   logic              err_q;

   logic              res_load, timeout_hit;
   logic              do_mult, fifo_pop;

   req_t              fifo_head;
   logic              fifo_full, fifo_empty;
   logic [FCNT_W-1:0] fifo_count;
   logic              unused_fifo_count;

   mult_req_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (bus.req_valid),
      .push_data_i ('{a: bus.req_a, b: bus.req_b}),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign unused_fifo_count = ^fifo_count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = '0;
      res_load    = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty && (!res_valid_q || bus.res_ready)) begin
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            state_d = WAIT;
         end
         WAIT: begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
            // First WAIT cycle skips mult_done: it may still be high from the previous product.
            if ((wait_cnt_q != '0) && bus.mult_done) begin
               res_load = 1'b1;
               state_d  = IDLE;
            end else if (wait_cnt_d == CNT_W'(TIMEOUT)) begin
               timeout_hit = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      do_mult  = (state_q == LAUNCH);
      fifo_pop = (state_q == LAUNCH);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mult_a_q    <= '0;
         mult_b_q    <= '0;
         res_out_q   <= '0;
         res_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if ((state_q == IDLE) && (state_d == LAUNCH)) begin
            mult_a_q <= fifo_head.a;
            mult_b_q <= fifo_head.b;
         end
         // A completing product wins over a same-cycle consume of the previous one.
         if (res_load) begin
            res_out_q   <= bus.mult_out;
            res_valid_q <= 1'b1;
         end else if (res_valid_q && bus.res_ready) begin
            res_valid_q <= 1'b0;
         end
         if (timeout_hit) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.req_ready   = !fifo_full;
   assign bus.mult_a      = mult_a_q;
   assign bus.mult_b      = mult_b_q;
   assign bus.doMult      = do_mult;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_out     = res_out_q;
   assign bus.err_timeout = err_q;

endmodule

// File: doc/mult_queue.md
MULT_QUEUE -- requirements
Module: mult_queue

Interface
REQ-001 Parameter DEPTH, default 4: request FIFO entries; power of two, at least 2.
REQ-002 Parameter TIMEOUT, default 64: maximum WAIT cycles allowed before mult_done.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-005 req_valid  input  1  upstream operand pair valid.
REQ-006 req_ready  output  1  queue can accept a pair this cycle.
REQ-007 req_a, req_b  input  32 each  unsigned operands.
REQ-008 mult_a, mult_b  output  32 each  operands to multu (a, b).
REQ-009 doMult  output  1  one-cycle start pulse to multu.
REQ-010 mult_done  input  1  multu completion, treated as a level.
REQ-011 mult_out  input  32  multu Out.
REQ-012 res_valid  output  1  result slot full.
REQ-013 res_ready  input  1  downstream accepts the result.
REQ-014 res_out  output  32  low 32 bits of a*b.
REQ-015 err_timeout  output  1  sticky timeout flag.

Function
REQ-016 A push SHALL occur on an edge where req_valid && req_ready; req_ready SHALL equal !full, with no bypass while full.
REQ-017 Simultaneous push and pop SHALL leave the count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-018 The FSM SHALL have states IDLE, LAUNCH and WAIT, and SHALL reset to IDLE.
REQ-019 IDLE -> LAUNCH SHALL occur when the FIFO is non-empty and the result slot is free, or is being consumed this cycle (res_valid && res_ready).
REQ-020 In LAUNCH, doMult=1 for exactly one cycle, mult_a/mult_b = FIFO head, and the head is popped; the next state is WAIT.
REQ-021 mult_a/mult_b SHALL be registered and held stable from LAUNCH until the next LAUNCH.
REQ-022 WAIT SHALL ignore mult_done on its first cycle, so that a stale done level is not captured.
REQ-023 On a later WAIT edge with mult_done=1:
- res_out <= mult_out
- res_valid <= 1
- next state IDLE
REQ-024 The result slot SHALL clear on res_valid && res_ready; a load and a clear on the same edge SHALL result in a load.
REQ-025 The WAIT counter SHALL start at 0 on entry; if it reaches TIMEOUT without mult_done:
- err_timeout <= 1
- no result is produced
- next state IDLE
REQ-026 err_timeout SHALL clear only on reset; the queue continues dispatching while it is set.
REQ-027 mult_done SHALL be ignored in IDLE and LAUNCH.
REQ-028 Minimum latency with an empty queue in IDLE: doMult high in the cycle after the second rising edge following the accepting edge.

Reset
REQ-029 On reset=0 at a rising edge:
- FIFO emptied (req_ready=1)
- state IDLE
- doMult=0
- res_valid=0, res_out=0
- mult_a=mult_b=0
- err_timeout=0
- WAIT counter=0
REQ-030 Reset mid-WAIT SHALL discard the in-flight operation; a mult_done arriving after reset SHALL be ignored.

Structure
REQ-031 Package mult_queue_pkg SHALL hold the state enum, DATA_W=32, and the DEPTH/TIMEOUT defaults.
REQ-032 FIFO SHALL be sub-module mult_req_fifo: 64-bit {a,b} entries, with full, empty and count outputs.
REQ-033 The counter width SHALL be clog2(TIMEOUT+1).

Verification
REQ-034 The bench SHALL use a behavioural multu model that raises mult_done 33 cycles after doMult and drops it on the next doMult.
REQ-035 Single op: push a=1, b=5 -> one doMult pulse, res_valid with res_out=5, err_timeout=0.
REQ-036 Back-pressure: push 4 pairs (2x3, 4x5, 6x7, 8x9) with res_ready=0 -> first result 6 holds; no second doMult until res_ready=1; then 20, 42, 72 in order.
REQ-037 Full: push 6 pairs back-to-back with DEPTH=4 -> req_ready=0 after 4 entries are held; no pair lost or duplicated; results in order.
REQ-038 Overflow: a=0xFFFFFFFF, b=2 -> res_out=0xFFFFFFFE.
REQ-039 Timeout: model never asserts done -> err_timeout=1 exactly TIMEOUT cycles after WAIT entry; next queued pair 3x3 still yields 9.
REQ-040 Reset mid-WAIT: reset=0 for 1 cycle -> all outputs at reset values; the late mult_done produces no res_valid.
